y86_fetch_unit: RTL
===================

// Module: y86_fetch_unit
// PURPOSE
//  Multi-cycle instruction fetch initiator for the SEQ core. Takes a PC from PC-select logic
//  and reads one byte per handshake over a byte-wide memory request port. Decodes length from
//  byte 0 and assembles one variable-length Y86-64 instruction. Presents the split fields and
//  the 80-bit packed instruction to decode under a valid/ready handshake.
// PARAMETERS
//  MEM_BYTES   601   memory size in bytes; used only when FETCH_ADDR_CHECK_EN is defined
// PORTS
//  clk            in   1   clock, all state updates on posedge
//  rst_n          in   1   asynchronous active-low reset
//  fetch_valid_i  in   1   PC request valid
//  fetch_ready_o  out  1   unit idle, accepts request
//  pc_i           in   64  instruction address (`WORD)
//  flush_i        in   1   abort in-flight fetch
//  mem_req_o      out  1   byte read request
//  mem_addr_o     out  64  byte address
//  mem_ack_i      in   1   byte returned this cycle
//  mem_rdata_i    in   8   returned byte
//  inst_valid_o   out  1   instruction fields valid
//  inst_ready_i   in   1   decode accepts instruction
//  inst_o         out  80  packed instruction (`INSTBUS), byte at pc in [79:72], unfetched bytes 0
//  icode_o/ifun_o out  4/4 byte0[7:4] / byte0[3:0]
//  rA_o/rB_o      out  4/4 register ids; 4'hF when the instruction has no register byte
//  valC_o         out  64  constant, little-endian; 0 when absent
//  valP_o         out  64  pc + length
//  instr_invalid_o out 1   icode > 4'hB
//  imem_error_o   out  1   address fault (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE, fetch_ready_o=1, mem_req_o=0, mem_addr_o=0, inst_valid_o=0,
//    inst_o/valC_o/valP_o=0, icode/ifun=0, rA/rB=4'hF, instr_invalid_o=0, imem_error_o=0.
//  - FSM: IDLE -> FETCH on fetch_valid_i. Latch pc, set cnt=0, drive mem_req_o=1, mem_addr_o=pc.
//    FETCH: on each mem_ack_i, capture byte cnt and increment cnt and mem_addr_o.
//    When cnt reaches len, go to DONE; mem_req_o falls the same edge.
//    DONE: inst_valid_o=1, all outputs stable; DONE -> IDLE on inst_ready_i.
//  - Handshake: mem_addr_o is held stable while mem_req_o=1 and mem_ack_i=0.
//    mem_ack_i may arrive in the same cycle as mem_req_o rises. Ack while req=0 is ignored.
//  - Length is decoded from byte 0 at its ack: icode 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9;
//    3,4,5 -> 10; icode > B -> 1 with instr_invalid_o=1.
//  - valC: bytes 2..9 for icode 3/4/5; bytes 1..8 for icode 7/8. valP = pc + len, 64-bit wrap.
//  - Latency: with ack every cycle, an L-byte instruction takes L FETCH cycles, then
//    inst_valid_o rises. fetch_ready_o is high only in IDLE, giving at least one idle cycle
//    between instructions.
//  - flush_i, any state except IDLE: next state IDLE, mem_req_o=0, inst_valid_o=0.
//    An ack coincident with flush_i is discarded. flush_i has priority over ack and inst_ready_i.
//  - rst_n low mid-fetch: immediately forces reset values, no further requests.
// CONFIGURATION
//  FETCH_ADDR_CHECK_EN defined:
//    - Before each request, the address is checked against MEM_BYTES-1.
//    - If it is out of range: no request is issued, go to DONE with imem_error_o=1,
//      icode_o=4'h1 (nop), ifun_o=0, valP_o=pc.
//  FETCH_ADDR_CHECK_EN not defined: no range logic, imem_error_o tied 0.
// TESTING
//  1 pc=0, bytes 30 F2 0A 00 00 00 00 00 00 00, ack every cycle -> 10 reqs at addr 0..9;
//    icode=3, rA=F, rB=2, valC=0xA, valP=10, inst_o=80'h30F20A00000000000000.
//  2 pc=0x20, byte 00; hold inst_ready_i=0 for 5 cycles -> 1 req; valP=0x21, rA=rB=F;
//    outputs stable and mem_req_o=0 while stalled.
//  3 pc=0x40, bytes 70 00 01 00.., ack every 3rd cycle -> mem_addr_o held between acks;
//    valC=0x100, valP=0x49.
//  4 pc=0, byte C0 -> 1 req, instr_invalid_o=1, valP=1.
//  5 irmovq at pc=0, flush_i after 3rd ack -> mem_req_o=0 next cycle, FSM in IDLE,
//    inst_valid_o never set.
//  6 FETCH_ADDR_CHECK_EN, MEM_BYTES=601, irmovq at pc=596 -> last req addr 600;
//    imem_error_o=1, icode=1.

Source files
------------

// File: rtl/y86_fetch_unit.sv
// Y86-64 multi-cycle byte-serial instruction fetch for the SEQ core.
// Optional address range check: define FETCH_ADDR_CHECK_EN.
module y86_fetch_unit #(
  parameter int MEM_BYTES = 601
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [63:0] pc_i,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [63:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [79:0] inst_o,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  rA_o,
  output logic [3:0]  rB_o,
  output logic [63:0] valC_o,
  output logic [63:0] valP_o,
  output logic        instr_invalid_o,
  output logic        imem_error_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [63:0]      addr_q, addr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       len_q, len_d;
  logic [0:9][7:0]  ibuf_q, ibuf_d;
  logic             err_q, err_d;
  logic [3:0]       len_eff;
  logic [3:0]       cnt_inc;
  logic [3:0]       icode;
  logic             has_reg;

  function automatic logic [3:0] len_of(
    input logic [3:0] ic
  );
    logic [3:0] l;
    case (ic)
      4'h0, 4'h1, 4'h9:       l = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: l = 4'd2;
      4'h7, 4'h8:             l = 4'd9;
      4'h3, 4'h4, 4'h5:       l = 4'd10;
      default:                l = 4'd1;
    endcase
    return l;
  endfunction

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [63:0] ADDR_MAX =
    64'(MEM_BYTES - 1);
  logic pc_bad;
  logic next_bad;
  assign pc_bad   = pc_i > ADDR_MAX;
  assign next_bad = (addr_q + 64'd1) > ADDR_MAX;
`else
  logic unused_cfg;
  assign unused_cfg = (MEM_BYTES != 0);
`endif

  assign cnt_inc = cnt_q + 4'd1;
  assign len_eff = (cnt_q == 4'd0)
                 ? len_of(mem_rdata_i[7:4])
                 : len_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ibuf_d  = ibuf_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (fetch_valid_i) begin
          pc_d    = pc_i;
          addr_d  = pc_i;
          cnt_d   = 4'd0;
          len_d   = 4'd0;
          ibuf_d  = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
`ifdef FETCH_ADDR_CHECK_EN
          // Out-of-range pc: report a nop with the fault.
          if (pc_bad) begin
            state_d   = S_DONE;
            err_d     = 1'b1;
            ibuf_d[0] = 8'h10;
          end
`endif
        end
      end
      S_FETCH: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (mem_ack_i) begin
          ibuf_d[cnt_q] = mem_rdata_i;
          cnt_d  = cnt_inc;
          addr_d = addr_q + 64'd1;
          len_d  = len_eff;
          if (cnt_inc == len_eff) begin
            state_d = S_DONE;
          end
`ifdef FETCH_ADDR_CHECK_EN
          else if (next_bad) begin
            state_d   = S_DONE;
            err_d     = 1'b1;
            len_d     = 4'd0;
            ibuf_d    = '0;
            ibuf_d[0] = 8'h10;
          end
`endif
        end
      end
      S_DONE: begin
        if (flush_i || inst_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ibuf_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ibuf_q  <= ibuf_d;
      err_q   <= err_d;
    end
  end

  assign icode = ibuf_q[0][7:4];

  always_comb begin
    has_reg = 1'b0;
    unique case (1'b1)
      icode == 4'h2,
      icode == 4'h3,
      icode == 4'h4,
      icode == 4'h5,
      icode == 4'h6,
      icode == 4'hA,
      icode == 4'hB: has_reg = 1'b1;
      default:       has_reg = 1'b0;
    endcase
  end

  always_comb begin
    valC_o = '0;
    case (icode)
      4'h3, 4'h4, 4'h5:
        valC_o = {ibuf_q[9], ibuf_q[8],
                  ibuf_q[7], ibuf_q[6],
                  ibuf_q[5], ibuf_q[4],
                  ibuf_q[3], ibuf_q[2]};
      4'h7, 4'h8:
        valC_o = {ibuf_q[8], ibuf_q[7],
                  ibuf_q[6], ibuf_q[5],
                  ibuf_q[4], ibuf_q[3],
                  ibuf_q[2], ibuf_q[1]};
      default: valC_o = '0;
    endcase
  end

  assign fetch_ready_o   = state_q == S_IDLE;
  assign mem_req_o       = state_q == S_FETCH;
  assign inst_valid_o    = state_q == S_DONE;
  assign mem_addr_o      = addr_q;
  assign inst_o          = ibuf_q;
  assign icode_o         = icode;
  assign ifun_o          = ibuf_q[0][3:0];
  assign rA_o            = has_reg ? ibuf_q[1][7:4]
                                   : 4'hF;
  assign rB_o            = has_reg ? ibuf_q[1][3:0]
                                   : 4'hF;
  assign valP_o          = pc_q + {60'd0, len_q};
  assign instr_invalid_o = icode > 4'hB;
  assign imem_error_o    = err_q;

endmodule
